perf_counter_bank: RTL
======================

// Module: perf_counter_bank
// PURPOSE
//  Parametrised bank of NUM_CNT event counters, CNT_W bits each, behind a CSR-style read/write port.
//  Adds what the fixed counter set lacks: writable counters, per-channel inhibit, sticky overflow flags
//  and a maskable overflow interrupt. Sits beside the CSR file, fed by the core's event strobes.
// PARAMETERS
//  NUM_CNT    8      number of counters, 1..32
//  CNT_W      64     counter width, XLEN < CNT_W <= 2*XLEN
//  XLEN       32     data bus width
//  ADDR_W     12     CSR address width
//  BASE_ADDR  12'hB00  address of offset 0x00
// PORTS
//  clk        in   1        clock
//  rst        in   1        asynchronous reset, active-high
//  clk_en     in   1        global clock enable; low = all state frozen
//  event_i    in   NUM_CNT  per-channel increment strobe (+1 per cycle when high)
//  re         in   1        read request
//  ra         in   ADDR_W   read address
//  rd         out  XLEN     read data, valid the cycle after re
//  rd_valid   out  1        qualifies rd/err
//  we         in   1        write request
//  wa         in   ADDR_W   write address
//  wd         in   XLEN     write data
//  err        out  1        unmapped access flag (read or write), same timing as rd_valid
//  ovf_irq    out  1        registered overflow interrupt
// BEHAVIOUR
//  Map (offset from BASE_ADDR): 0x00+i cnt[i] low XLEN bits; 0x20+i cnt[i] high (CNT_W-XLEN bits, zero-ext);
//   0x40 inhibit[NUM_CNT-1:0] RW; 0x41 ovf[NUM_CNT-1:0] read / write-1-to-clear; 0x42 ovf_ie RW.
//   Offsets with i >= NUM_CNT, other offsets, and addresses outside the block are unmapped.
//  Reset (async, rst=1): all counters, inhibit, ovf, ovf_ie, rd, rd_valid, err, ovf_irq = 0.
//  All updates occur on rising clk only when clk_en=1; clk_en=0 holds every register, rd_valid included.
//  Count: cnt[i] <= cnt[i]+1 when event_i[i] & ~inhibit[i]; modulo 2^CNT_W.
//  Wrap: cnt[i] going all-ones -> 0 sets ovf[i] (sticky).
//  Write low/high half: replaces that half only, other half unchanged; increment suppressed that cycle
//   for that counter (write wins, no carry, no ovf set). Upper unused wd bits of high half ignored.
//  Write 0x41: ovf[i] cleared where wd[i]=1; a same-cycle wrap on channel i sets ovf[i] (set wins).
//  Inhibit write takes effect for events from the next cycle.
//  Read: registered, latency 1; rd_valid <= re. rd returns pre-update value (value before same-cycle write).
//   Unmapped read: rd=0, err=1 with rd_valid. Unmapped write: no state change, err=1 next cycle,
//   rd_valid not asserted by the write alone.
//  No read/write ready handshake: one access of each kind per cycle, read and write may be simultaneous.
//  64-bit read is two independent accesses; software handles low/high tearing.
//  ovf_irq <= |(ovf_next & ovf_ie_next); one cycle after the flag/enable change.
//  Reset mid-operation: immediate return to reset values; pending read is dropped (rd_valid=0).
// TESTING
//  Reset: assert rst mid-count -> rd_valid, err, ovf_irq, all counters read 0 after release.
//  Count/read: event_i[2]=1 for 10 cycles, read 0x02 -> rd=10, rd_valid one cycle after re; 0x22 -> 0.
//  Wrap: write cnt[1] low/high 0xFFFFFFFF, ovf_ie=0x2, one event -> cnt[1]=0, ovf=0x2, ovf_irq=1 next cycle.
//  Collision: write cnt[0] low=5 while event_i[0]=1 -> reads 5; W1C ovf[1] same cycle as new wrap -> ovf[1]=1.
//  Inhibit/clk_en: inhibit=0x1 or clk_en=0 for 20 events -> cnt[0] unchanged; other channels per clk_en.
//  Unmapped: NUM_CNT=8, read 0x09 and write 0x50 -> err=1, rd=0, no state changes.

Source files
------------

// File: rtl/perf_counter_bank.sv
// Bank of writable event counters with per-channel inhibit, sticky overflow flags
// and a maskable overflow interrupt, accessed through a CSR-style read/write port.
module perf_counter_bank #(
  parameter int unsigned       NUM_CNT   = 8,
  parameter int unsigned       CNT_W     = 64,
  parameter int unsigned       XLEN      = 32,
  parameter int unsigned       ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 12'hB00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic [NUM_CNT-1:0] event_i,
  input  logic               re,
  input  logic [ADDR_W-1:0]  ra,
  output logic [XLEN-1:0]    rd,
  output logic               rd_valid,
  input  logic               we,
  input  logic [ADDR_W-1:0]  wa,
  input  logic [XLEN-1:0]    wd,
  output logic               err,
  output logic               ovf_irq
);

  localparam int unsigned HiW = CNT_W - XLEN;

  typedef enum logic [2:0] {SelNone, SelLo, SelHi, SelInh, SelOvf, SelIe} sel_e;

  logic [NUM_CNT-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CNT-1:0]            inhibit_q, inhibit_d;
  logic [NUM_CNT-1:0]            ovf_q, ovf_d;
  logic [NUM_CNT-1:0]            ovf_ie_q, ovf_ie_d;
  logic [NUM_CNT-1:0]            w1c, wrap;
  logic [XLEN-1:0]               rd_d;
  logic                          err_d, irq_d;
  sel_e                          r_sel, w_sel;
  logic [4:0]                    r_idx, w_idx;

  // Addresses below BASE_ADDR are caught by the borrow of the widened subtraction.
  function automatic sel_e decode(input logic [ADDR_W-1:0] addr, output logic [4:0] idx);
    logic [ADDR_W:0]   diff;
    logic [ADDR_W-1:0] off;
    diff = {1'b0, addr} - {1'b0, BASE_ADDR};
    off  = diff[ADDR_W-1:0];
    idx  = off[4:0];
    if (diff[ADDR_W]) return SelNone;
    if (off < ADDR_W'(32)) return (32'(idx) < NUM_CNT) ? SelLo : SelNone;
    if (off < ADDR_W'(64)) return (32'(idx) < NUM_CNT) ? SelHi : SelNone;
    if (off == ADDR_W'(64)) return SelInh;
    if (off == ADDR_W'(65)) return SelOvf;
    if (off == ADDR_W'(66)) return SelIe;
    return SelNone;
  endfunction

  always_comb begin
    r_sel     = decode(ra, r_idx);
    w_sel     = decode(wa, w_idx);
    rd_d      = '0;
    inhibit_d = inhibit_q;
    ovf_ie_d  = ovf_ie_q;
    w1c       = '0;
    wrap      = '0;
    cnt_d     = cnt_q;

    // Read side sees the pre-update state.
    if (re) begin
      case (r_sel)
        SelLo: begin
          for (int i = 0; i < NUM_CNT; i++) begin
            if (r_idx == 5'(i)) rd_d = cnt_q[i][XLEN-1:0];
          end
        end
        SelHi: begin
          for (int i = 0; i < NUM_CNT; i++) begin
            if (r_idx == 5'(i)) rd_d[HiW-1:0] = cnt_q[i][CNT_W-1:XLEN];
          end
        end
        SelInh:  rd_d[NUM_CNT-1:0] = inhibit_q;
        SelOvf:  rd_d[NUM_CNT-1:0] = ovf_q;
        SelIe:   rd_d[NUM_CNT-1:0] = ovf_ie_q;
        default: rd_d = '0;
      endcase
    end

    if (we) begin
      case (w_sel)
        SelInh:  inhibit_d = wd[NUM_CNT-1:0];
        SelOvf:  w1c = wd[NUM_CNT-1:0];
        SelIe:   ovf_ie_d = wd[NUM_CNT-1:0];
        default: ;
      endcase
    end

    // A half-write replaces the increment for that channel: no carry, no overflow.
    for (int i = 0; i < NUM_CNT; i++) begin
      if (we && w_sel == SelLo && w_idx == 5'(i)) begin
        cnt_d[i][XLEN-1:0] = wd;
      end else if (we && w_sel == SelHi && w_idx == 5'(i)) begin
        cnt_d[i][CNT_W-1:XLEN] = wd[HiW-1:0];
      end else if (event_i[i] && !inhibit_q[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
        wrap[i]  = &cnt_q[i];
      end
    end

    ovf_d = (ovf_q & ~w1c) | wrap;
    irq_d = |(ovf_d & ovf_ie_d);
    err_d = (re && r_sel == SelNone) || (we && w_sel == SelNone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      inhibit_q <= '0;
      ovf_q     <= '0;
      ovf_ie_q  <= '0;
      rd        <= '0;
      rd_valid  <= 1'b0;
      err       <= 1'b0;
      ovf_irq   <= 1'b0;
    end else if (clk_en) begin
      cnt_q     <= cnt_d;
      inhibit_q <= inhibit_d;
      ovf_q     <= ovf_d;
      ovf_ie_q  <= ovf_ie_d;
      rd        <= rd_d;
      rd_valid  <= re;
      err       <= err_d;
      ovf_irq   <= irq_d;
    end
  end

endmodule
